// File: rtl/lsu_bus_ctrl.sv
// Load/store unit: func3-coded accesses to a handshaked word bus with byte enables and load extension.
// Build option LSU_MISALIGN_SPLIT_EN: word-crossing misaligned accesses run as two bus transactions.
module lsu_bus_ctrl #(
    parameter int unsigned XLEN        = 32,
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned TIMEOUT_CYC = 64
) (
    input  logic              CLK,
    input  logic              Reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_load,
    input  logic              req_store,
    input  logic [2:0]        req_func3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [XLEN-1:0]   req_wdata,
    input  logic              flush,
    output logic              stall,
    output logic              rsp_valid,
    output logic [XLEN-1:0]   rsp_rdata,
    output logic [1:0]        rsp_fault,
    output logic [ADDR_W-1:0] MEM_addr,
    output logic [XLEN-1:0]   MEM_WR_out,
    output logic [XLEN/8-1:0] MEM_be,
    output logic              MEM_rd_en,
    output logic              MEM_wr_en,
    input  logic              MEM_ack,
    input  logic [XLEN-1:0]   MEM_data
);
    localparam int unsigned LANES   = XLEN / 8;
    localparam int unsigned OFF_W   = $clog2(LANES);
    localparam int unsigned CNT_W   = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;
    localparam int unsigned TO_LAST = (TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0;
`ifdef LSU_MISALIGN_SPLIT_EN
    localparam int unsigned SPAN    = 2;
`else
    localparam int unsigned SPAN    = 1;
`endif
    localparam int unsigned BE_W    = SPAN * LANES;
    localparam int unsigned WD_W    = SPAN * XLEN;

    localparam logic [1:0] F_OK = 2'b00, F_MIS = 2'b01, F_ILL = 2'b10, F_TO = 2'b11;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCESS  = 2'd1,
        RESP    = 2'd2
`ifdef LSU_MISALIGN_SPLIT_EN
        , ACCESS2 = 2'd3
`endif
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [XLEN-1:0]     wd_q, wd_d;
    logic [LANES-1:0]    be_q, be_d;
    logic                rd_en_q, rd_en_d, wr_en_q, wr_en_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                flush_q, flush_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic [XLEN-1:0]     rsp_rdata_q, rsp_rdata_d;
    logic [1:0]          rsp_fault_q, rsp_fault_d;
    logic [OFF_W-1:0]    off_q, off_d;
    logic [2:0]          f3_q, f3_d;
    logic                is_ld_q, is_ld_d;
`ifdef LSU_MISALIGN_SPLIT_EN
    logic [ADDR_W-1:0]   hi_addr_q, hi_addr_d;
    logic [LANES-1:0]    hi_be_q, hi_be_d;
    logic [XLEN-1:0]     hi_wd_q, hi_wd_d;
    logic                split_q, split_d;
    logic [XLEN-1:0]     lo_data_q, lo_data_d;
`endif

    logic                f3_ok, illegal, mis, timeout;
    logic [ADDR_W-1:0]   word_addr;
    logic [XLEN-1:0]     st_mask, ld_mask, ld_raw, ld_ext;
    logic [BE_W-1:0]     be_wide;
    logic [WD_W-1:0]     wd_wide, ld_cat;
    logic                ld_sign;

    // Request decode: legality, alignment, lane enables and lane-shifted store data
    always_comb begin
        f3_ok = 1'b0;
        case (req_func3)
            3'b000, 3'b001, 3'b010, 3'b100, 3'b101: f3_ok = 1'b1;
            3'b011, 3'b110:                         f3_ok = (XLEN == 64);
            default:                                f3_ok = 1'b0;
        endcase
        if (req_store && req_func3[2]) f3_ok = 1'b0;
        illegal   = (req_load == req_store) || !f3_ok;
        mis       = (req_addr[OFF_W-1:0] & OFF_W'((32'd1 << req_func3[1:0]) - 32'd1)) != '0;
        word_addr = {req_addr[ADDR_W-1:OFF_W], OFF_W'(0)};
        st_mask   = ~({XLEN{1'b1}} << (32'd8 << req_func3[1:0]));
        be_wide   = BE_W'((32'd1 << (32'd1 << req_func3[1:0])) - 32'd1) << req_addr[OFF_W-1:0];
        wd_wide   = WD_W'(req_wdata & st_mask) << {req_addr[OFF_W-1:0], 3'b000};
    end

    // Load path: select lanes (merging both words after a split) and extend
    always_comb begin
`ifdef LSU_MISALIGN_SPLIT_EN
        ld_cat = (state_q == ACCESS2) ? {MEM_data, lo_data_q} : {XLEN'(0), MEM_data};
`else
        ld_cat = MEM_data;
`endif
        ld_raw  = XLEN'(ld_cat >> {off_q, 3'b000});
        ld_mask = ~({XLEN{1'b1}} << (32'd8 << f3_q[1:0]));
        ld_sign = ((ld_raw & ld_mask & ~(ld_mask >> 1)) != '0) && !f3_q[2];
        ld_ext  = (ld_raw & ld_mask) | (ld_sign ? ~ld_mask : '0);
        timeout = (TIMEOUT_CYC != 0) && (cnt_q == CNT_W'(TO_LAST));
    end

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wd_d        = wd_q;
        be_d        = be_q;
        rd_en_d     = rd_en_q;
        wr_en_d     = wr_en_q;
        cnt_d       = cnt_q;
        flush_d     = flush_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        rsp_fault_d = rsp_fault_q;
        off_d       = off_q;
        f3_d        = f3_q;
        is_ld_d     = is_ld_q;
`ifdef LSU_MISALIGN_SPLIT_EN
        hi_addr_d   = hi_addr_q;
        hi_be_d     = hi_be_q;
        hi_wd_d     = hi_wd_q;
        split_d     = split_q;
        lo_data_d   = lo_data_q;
`endif
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    off_d   = req_addr[OFF_W-1:0];
                    f3_d    = req_func3;
                    is_ld_d = req_load;
                    flush_d = 1'b0;
                    cnt_d   = '0;
                    if (illegal) begin
                        state_d     = RESP;
                        rsp_valid_d = 1'b1;
                        rsp_fault_d = F_ILL;
                        rsp_rdata_d = '0;
                    end
`ifndef LSU_MISALIGN_SPLIT_EN
                    else if (mis) begin
                        state_d     = RESP;
                        rsp_valid_d = 1'b1;
                        rsp_fault_d = F_MIS;
                        rsp_rdata_d = '0;
                    end
`endif
                    else begin
                        state_d = ACCESS;
                        addr_d  = word_addr;
                        be_d    = be_wide[LANES-1:0];
                        wd_d    = wd_wide[XLEN-1:0];
                        rd_en_d = req_load;
                        wr_en_d = req_store;
`ifdef LSU_MISALIGN_SPLIT_EN
                        hi_addr_d = word_addr + ADDR_W'(LANES);
                        hi_be_d   = be_wide[BE_W-1:LANES];
                        hi_wd_d   = wd_wide[WD_W-1:XLEN];
                        split_d   = mis && (be_wide[BE_W-1:LANES] != '0);
`endif
                    end
                end
            end
`ifdef LSU_MISALIGN_SPLIT_EN
            ACCESS, ACCESS2: begin
`else
            ACCESS: begin
`endif
                if (flush) flush_d = 1'b1;
                if (MEM_ack) begin
                    cnt_d = '0;
`ifdef LSU_MISALIGN_SPLIT_EN
                    if (state_q == ACCESS && split_q) begin
                        state_d   = ACCESS2;
                        addr_d    = hi_addr_q;
                        be_d      = hi_be_q;
                        wd_d      = hi_wd_q;
                        lo_data_d = MEM_data;
                    end else
`endif
                    begin
                        state_d     = RESP;
                        {addr_d, be_d, wd_d, rd_en_d, wr_en_d} = '0;
                        rsp_valid_d = !(flush_q || flush);
                        rsp_fault_d = F_OK;
                        rsp_rdata_d = is_ld_q ? ld_ext : '0;
                    end
                end else if (timeout) begin
                    // Late acks after this point are ignored: the strobes are already gone
                    state_d     = RESP;
                    {addr_d, be_d, wd_d, rd_en_d, wr_en_d} = '0;
                    rsp_valid_d = !(flush_q || flush);
                    rsp_fault_d = F_TO;
                    rsp_rdata_d = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RESP: begin
                state_d     = IDLE;
                rsp_rdata_d = '0;
                rsp_fault_d = '0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            wd_q        <= '0;
            be_q        <= '0;
            rd_en_q     <= 1'b0;
            wr_en_q     <= 1'b0;
            cnt_q       <= '0;
            flush_q     <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_fault_q <= '0;
            off_q       <= '0;
            f3_q        <= '0;
            is_ld_q     <= 1'b0;
`ifdef LSU_MISALIGN_SPLIT_EN
            hi_addr_q   <= '0;
            hi_be_q     <= '0;
            hi_wd_q     <= '0;
            split_q     <= 1'b0;
            lo_data_q   <= '0;
`endif
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            wd_q        <= wd_d;
            be_q        <= be_d;
            rd_en_q     <= rd_en_d;
            wr_en_q     <= wr_en_d;
            cnt_q       <= cnt_d;
            flush_q     <= flush_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_fault_q <= rsp_fault_d;
            off_q       <= off_d;
            f3_q        <= f3_d;
            is_ld_q     <= is_ld_d;
`ifdef LSU_MISALIGN_SPLIT_EN
            hi_addr_q   <= hi_addr_d;
            hi_be_q     <= hi_be_d;
            hi_wd_q     <= hi_wd_d;
            split_q     <= split_d;
            lo_data_q   <= lo_data_d;
`endif
        end
    end

    // A flush during the response cycle still cancels the pulse
    assign req_ready  = (state_q == IDLE);
    assign stall      = (state_q != IDLE) || (req_valid && req_ready);
    assign rsp_valid  = rsp_valid_q && !flush;
    assign rsp_rdata  = rsp_rdata_q;
    assign rsp_fault  = rsp_fault_q;
    assign MEM_addr   = addr_q;
    assign MEM_WR_out = wd_q;
    assign MEM_be     = be_q;
    assign MEM_rd_en  = rd_en_q;
    assign MEM_wr_en  = wr_en_q;
endmodule
